// File: rtl/handshake_scenario_monitor_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | handshake_mon_pkg : shared types, indices and helpers for the monitor |
// | Revision: 1.0                                                         |
// +----------------------------------------------------------------------+
package handshake_mon_pkg;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_WAIT   = 2'd1,
    S_ACTIVE = 2'd2
  } trk_state_e;

  localparam int SCN_FULL_TP      = 0;
  localparam int SCN_BACKPRESSURE = 1;
  localparam int SCN_STARVED      = 2;
  localparam int SCN_SIMULT       = 3;
  localparam int SCN_ALTERNATE    = 4;
  localparam int SCN_BURST_IDLE   = 5;
  localparam int NUM_SCN          = 6;

  localparam logic [2:0] SEL_XFER  = 3'd0;
  localparam logic [2:0] SEL_PKT   = 3'd1;
  localparam logic [2:0] SEL_STALL = 3'd2;
  localparam logic [2:0] SEL_MAXW  = 3'd3;
  localparam logic [2:0] SEL_PERR  = 3'd4;

  // Saturating increment of a w-bit value carried in 32 bits (w <= 32).
  function automatic logic [31:0] sat_inc(input logic [31:0] v, input int unsigned w);
    logic [31:0] max_v;
    max_v = 32'hFFFF_FFFF >> (32 - w);
    return (v >= max_v) ? v : v + 32'd1;
  endfunction

endpackage
`default_nettype wire

// File: rtl/handshake_scenario_monitor_if.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | handshake_scenario_monitor_if : bundle of per-channel valid/ready/last|
// | Revision: 1.0                                                         |
// +----------------------------------------------------------------------+
interface handshake_scenario_monitor_if #(
  parameter int NUM_CH = 4
) ();
  logic [NUM_CH-1:0] valid;
  logic [NUM_CH-1:0] ready;
  logic [NUM_CH-1:0] last;

  modport master (output valid, ready, last);
  modport slave  (input  valid, ready, last);
endinterface
`default_nettype wire

// File: rtl/handshake_scenario_monitor_tracker.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | hs_channel_tracker : one channel's FSM, run counters, stats and hits  |
// | Revision: 1.0                                                         |
// +----------------------------------------------------------------------+
module hs_channel_tracker
  import handshake_mon_pkg::*;
#(
  parameter int CNT_W     = 16,
  parameter int BURST_LEN = 5,
  parameter int WAIT_LEN  = 2,
  parameter int IDLE_LEN  = 5
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               clear,
  input  logic               valid,
  input  logic               ready,
  input  logic               last,
  output logic [NUM_SCN-1:0] hit,
  output logic               proto_err,
  output logic [CNT_W-1:0]   xfer_cnt,
  output logic [CNT_W-1:0]   pkt_cnt,
  output logic [CNT_W-1:0]   stall_cnt,
  output logic [CNT_W-1:0]   max_wait,
  output logic [CNT_W-1:0]   perr_cnt
);

  localparam logic [CNT_W-1:0] c_burst_len = CNT_W'(BURST_LEN);
  localparam logic [CNT_W-1:0] c_wait_len  = CNT_W'(WAIT_LEN);
  localparam logic [CNT_W-1:0] c_idle_len  = CNT_W'(IDLE_LEN);

  function automatic logic [CNT_W-1:0] inc(input logic [CNT_W-1:0] v);
    logic [31:0] t;
    t = sat_inc(32'(v), CNT_W);
    return t[CNT_W-1:0];
  endfunction

  trk_state_e         state_q, state_d;
  logic               pp_xfer_q, pp_xfer_d;
  logic               burst_seen_q, burst_seen_d;
  logic [CNT_W-1:0]   xfer_run_q, xfer_run_d;
  logic [CNT_W-1:0]   stall_run_q, stall_run_d;
  logic [CNT_W-1:0]   starve_run_q, starve_run_d;
  logic [CNT_W-1:0]   idle_run_q, idle_run_d;
  logic [CNT_W-1:0]   xfer_cnt_q, xfer_cnt_d;
  logic [CNT_W-1:0]   pkt_cnt_q, pkt_cnt_d;
  logic [CNT_W-1:0]   stall_cnt_q, stall_cnt_d;
  logic [CNT_W-1:0]   max_wait_q, max_wait_d;
  logic [CNT_W-1:0]   perr_cnt_q, perr_cnt_d;
  logic [NUM_SCN-1:0] hit_q, hit_d;
  logic               proto_err_q, proto_err_d;

  logic is_xfer, is_stall, is_starve, prev_none, perr_ev;

  always_comb begin
    is_xfer   = valid & ready;
    is_stall  = valid & ~ready;
    is_starve = ~valid & ready;
    // Previous cycle was NONE exactly when a !valid run is open but no starve run is.
    prev_none = (idle_run_q != '0) && (starve_run_q == '0);
    perr_ev   = (state_q == S_WAIT) && !valid;

    state_d = S_IDLE;
    if (is_xfer) begin
      state_d = S_ACTIVE;
    end else if (is_stall) begin
      state_d = S_WAIT;
    end
    pp_xfer_d = (state_q == S_ACTIVE);

    xfer_run_d   = is_xfer   ? inc(xfer_run_q)   : '0;
    stall_run_d  = is_stall  ? inc(stall_run_q)  : '0;
    starve_run_d = is_starve ? inc(starve_run_q) : '0;
    idle_run_d   = !valid    ? inc(idle_run_q)   : '0;

    // A long enough burst stays armed through the following !valid cycles only.
    burst_seen_d = is_xfer ? (xfer_run_d >= c_burst_len) : (!valid && burst_seen_q);

    hit_d = hit_q;
    if (is_xfer && (xfer_run_d >= c_burst_len))  hit_d[SCN_FULL_TP]      = 1'b1;
    if (is_xfer && (stall_run_q >= c_wait_len))  hit_d[SCN_BACKPRESSURE] = 1'b1;
    if (is_xfer && (starve_run_q >= c_wait_len)) hit_d[SCN_STARVED]      = 1'b1;
    if (is_xfer && prev_none)                    hit_d[SCN_SIMULT]       = 1'b1;
    if (is_xfer && (state_q != S_ACTIVE) && pp_xfer_q) hit_d[SCN_ALTERNATE] = 1'b1;
    if (!valid && burst_seen_q && (idle_run_d == c_idle_len)) hit_d[SCN_BURST_IDLE] = 1'b1;

    xfer_cnt_d  = is_xfer          ? inc(xfer_cnt_q)  : xfer_cnt_q;
    pkt_cnt_d   = (is_xfer && last) ? inc(pkt_cnt_q)  : pkt_cnt_q;
    stall_cnt_d = is_stall         ? inc(stall_cnt_q) : stall_cnt_q;
    max_wait_d  = (is_stall && (stall_run_d > max_wait_q)) ? stall_run_d : max_wait_q;
    perr_cnt_d  = perr_ev          ? inc(perr_cnt_q)  : perr_cnt_q;
    proto_err_d = proto_err_q | perr_ev;

    if (clear) begin
      state_d      = S_IDLE;
      pp_xfer_d    = 1'b0;
      burst_seen_d = 1'b0;
      xfer_run_d   = '0;
      stall_run_d  = '0;
      starve_run_d = '0;
      idle_run_d   = '0;
      hit_d        = '0;
      xfer_cnt_d   = '0;
      pkt_cnt_d    = '0;
      stall_cnt_d  = '0;
      max_wait_d   = '0;
      perr_cnt_d   = '0;
      proto_err_d  = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= S_IDLE;
      pp_xfer_q    <= 1'b0;
      burst_seen_q <= 1'b0;
      xfer_run_q   <= '0;
      stall_run_q  <= '0;
      starve_run_q <= '0;
      idle_run_q   <= '0;
      hit_q        <= '0;
      xfer_cnt_q   <= '0;
      pkt_cnt_q    <= '0;
      stall_cnt_q  <= '0;
      max_wait_q   <= '0;
      perr_cnt_q   <= '0;
      proto_err_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      pp_xfer_q    <= pp_xfer_d;
      burst_seen_q <= burst_seen_d;
      xfer_run_q   <= xfer_run_d;
      stall_run_q  <= stall_run_d;
      starve_run_q <= starve_run_d;
      idle_run_q   <= idle_run_d;
      hit_q        <= hit_d;
      xfer_cnt_q   <= xfer_cnt_d;
      pkt_cnt_q    <= pkt_cnt_d;
      stall_cnt_q  <= stall_cnt_d;
      max_wait_q   <= max_wait_d;
      perr_cnt_q   <= perr_cnt_d;
      proto_err_q  <= proto_err_d;
    end
  end

  assign hit       = hit_q;
  assign proto_err = proto_err_q;
  assign xfer_cnt  = xfer_cnt_q;
  assign pkt_cnt   = pkt_cnt_q;
  assign stall_cnt = stall_cnt_q;
  assign max_wait  = max_wait_q;
  assign perr_cnt  = perr_cnt_q;

endmodule
`default_nettype wire

// File: rtl/handshake_scenario_monitor.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | handshake_scenario_monitor : NUM_CH channel trackers + registered read|
// | Revision: 1.0                                                         |
// +----------------------------------------------------------------------+
module handshake_scenario_monitor
  import handshake_mon_pkg::*;
#(
  parameter int NUM_CH    = 4,
  parameter int CNT_W     = 16,
  parameter int BURST_LEN = 5,
  parameter int WAIT_LEN  = 2,
  parameter int IDLE_LEN  = 5
) (
  input  logic                        clk,
  input  logic                        rst,
  handshake_scenario_monitor_if.slave mon,
  input  logic                        clear,
  input  logic [$clog2(NUM_CH)-1:0]   rd_ch,
  input  logic [2:0]                  rd_sel,
  output logic [CNT_W-1:0]            rd_data,
  output logic [NUM_CH*NUM_SCN-1:0]   hit,
  output logic [NUM_CH-1:0]           proto_err
);

  localparam int CH_W = $clog2(NUM_CH);

  logic [NUM_CH-1:0][CNT_W-1:0] sel_val;
  logic [CNT_W-1:0]             rd_data_q, rd_data_d;

  for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
    logic [CNT_W-1:0] xfer_cnt, pkt_cnt, stall_cnt, max_wait, perr_cnt;
    logic [CNT_W-1:0] ch_val;

    hs_channel_tracker #(
      .CNT_W     (CNT_W),
      .BURST_LEN (BURST_LEN),
      .WAIT_LEN  (WAIT_LEN),
      .IDLE_LEN  (IDLE_LEN)
    ) u_trk (
      .clk       (clk),
      .rst       (rst),
      .clear     (clear),
      .valid     (mon.valid[c]),
      .ready     (mon.ready[c]),
      .last      (mon.last[c]),
      .hit       (hit[c*NUM_SCN +: NUM_SCN]),
      .proto_err (proto_err[c]),
      .xfer_cnt  (xfer_cnt),
      .pkt_cnt   (pkt_cnt),
      .stall_cnt (stall_cnt),
      .max_wait  (max_wait),
      .perr_cnt  (perr_cnt)
    );

    always_comb begin
      ch_val = '0;
      case (rd_sel)
        SEL_XFER:  ch_val = xfer_cnt;
        SEL_PKT:   ch_val = pkt_cnt;
        SEL_STALL: ch_val = stall_cnt;
        SEL_MAXW:  ch_val = max_wait;
        SEL_PERR:  ch_val = perr_cnt;
        default:   ch_val = '0;
      endcase
    end

    // Out-of-range rd_ch matches no channel and therefore reads 0.
    assign sel_val[c] = (rd_ch == CH_W'(c)) ? ch_val : '0;
  end

  always_comb begin
    rd_data_d = '0;
    for (int c = 0; c < NUM_CH; c++) begin
      rd_data_d = rd_data_d | sel_val[c];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rd_data_q <= '0;
    end else begin
      rd_data_q <= rd_data_d;
    end
  end

  assign rd_data = rd_data_q;

endmodule
`default_nettype wire

// File: tb/tb_handshake_scenario_monitor.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_handshake_scenario_monitor : directed self-checking bench          |
// | Revision: 1.0                                                         |
// +----------------------------------------------------------------------+
module tb_handshake_scenario_monitor;

  localparam int NUM_CH    = 4;
  localparam int CNT_W     = 8;
  localparam int BURST_LEN = 5;
  localparam int WAIT_LEN  = 2;
  localparam int IDLE_LEN  = 5;

  logic                 clk = 1'b0;
  logic                 rst;
  logic                 clear;
  logic [1:0]           rd_ch;
  logic [2:0]           rd_sel;
  logic [CNT_W-1:0]     rd_data;
  logic [NUM_CH*6-1:0]  hit;
  logic [NUM_CH-1:0]    proto_err;

  int n_checks = 0;
  int n_errors = 0;

  handshake_scenario_monitor_if #(.NUM_CH(NUM_CH)) bus ();

  handshake_scenario_monitor #(
    .NUM_CH    (NUM_CH),
    .CNT_W     (CNT_W),
    .BURST_LEN (BURST_LEN),
    .WAIT_LEN  (WAIT_LEN),
    .IDLE_LEN  (IDLE_LEN)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .mon       (bus),
    .clear     (clear),
    .rd_ch     (rd_ch),
    .rd_sel    (rd_sel),
    .rd_data   (rd_data),
    .hit       (hit),
    .proto_err (proto_err)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_all();
    bus.valid = '0;
    bus.ready = '0;
    bus.last  = '0;
  endtask

  task automatic set_ch(input int ch, input logic v, input logic r, input logic l);
    idle_all();
    bus.valid[ch] = v;
    bus.ready[ch] = r;
    bus.last[ch]  = l;
  endtask

  task automatic rd_check(input string tag, input int ch, input int sel, input logic [31:0] exp);
    rd_ch  = 2'(ch);
    rd_sel = 3'(sel);
    cyc();
    check(tag, 32'(rd_data), exp);
  endtask

  initial begin
    rst = 1'b1;
    clear = 1'b0;
    rd_ch = '0;
    rd_sel = '0;
    idle_all();
    repeat (2) cyc();
    check("rst_hit", 32'(hit), 32'h0);
    check("rst_perr", 32'(proto_err), 32'h0);
    check("rst_rd", 32'(rd_data), 32'h0);
    rst = 1'b0;

    // Burst then idle on ch0
    set_ch(0, 1'b1, 1'b1, 1'b0);
    for (int i = 1; i <= 5; i++) begin
      cyc();
      if (i == 4) check("fulltp_early", 32'(hit[0]), 32'h0);
    end
    check("fulltp", 32'(hit[0]), 32'h1);
    idle_all();
    for (int i = 1; i <= 5; i++) begin
      cyc();
      if (i == 4) check("burstidle_early", 32'(hit[5]), 32'h0);
    end
    check("burstidle", 32'(hit[5]), 32'h1);
    check("ch0_hits", 32'(hit[5:0]), 32'h21);
    rd_check("ch0_xfer", 0, 0, 32'd5);
    check("other_hits", 32'(hit[23:6]), 32'h0);

    // Backpressure on ch1
    set_ch(1, 1'b1, 1'b0, 1'b0);
    repeat (3) cyc();
    set_ch(1, 1'b1, 1'b1, 1'b1);
    cyc();
    idle_all();
    check("bp_hits", 32'(hit[11:6]), 32'h02);
    rd_check("bp_stall", 1, 2, 32'd3);
    rd_check("bp_maxw", 1, 3, 32'd3);
    rd_check("bp_pkt", 1, 1, 32'd1);
    rd_check("bp_xfer", 1, 0, 32'd1);
    check("bp_perr", 32'(proto_err), 32'h0);

    // Dropped valid on ch2
    set_ch(2, 1'b1, 1'b0, 1'b0);
    cyc();
    check("drop_pre", 32'(proto_err[2]), 32'h0);
    idle_all();
    cyc();
    check("drop_perr", 32'(proto_err), 32'h4);
    rd_check("drop_cnt", 2, 4, 32'd1);
    rd_check("sel5_zero", 2, 5, 32'd0);

    // Saturation on ch3
    set_ch(3, 1'b1, 1'b1, 1'b0);
    repeat (300) cyc();
    rd_check("sat_xfer", 3, 0, 32'd255);
    rd_check("sat_hold", 3, 0, 32'd255);
    check("sat_fulltp", 32'(hit[18]), 32'h1);
    idle_all();

    // Clear precedence, then SIMULT and ALTERNATE on ch0
    set_ch(0, 1'b1, 1'b1, 1'b0);
    clear = 1'b1;
    cyc();
    clear = 1'b0;
    idle_all();
    check("clr_hit", 32'(hit), 32'h0);
    check("clr_perr", 32'(proto_err), 32'h0);
    rd_check("clr_ch0", 0, 0, 32'd0);
    rd_check("clr_ch3", 3, 0, 32'd0);
    cyc();
    set_ch(0, 1'b1, 1'b1, 1'b0);
    cyc();
    check("simult", 32'(hit[3]), 32'h1);
    check("alt_early", 32'(hit[4]), 32'h0);
    idle_all();
    cyc();
    set_ch(0, 1'b1, 1'b1, 1'b0);
    cyc();
    check("alternate", 32'(hit[4]), 32'h1);
    idle_all();
    rd_check("clr_count", 0, 0, 32'd2);

    // Reset in the middle of a ch0 burst
    set_ch(0, 1'b1, 1'b1, 1'b0);
    repeat (2) cyc();
    rst = 1'b1;
    cyc();
    rst = 1'b0;
    check("mrst_hit", 32'(hit), 32'h0);
    check("mrst_perr", 32'(proto_err), 32'h0);
    check("mrst_rd", 32'(rd_data), 32'h0);
    rd_ch = 2'd0;
    rd_sel = 3'd0;
    cyc();
    check("mrst_cnt0", 32'(rd_data), 32'd0);
    cyc();
    check("mrst_cnt1", 32'(rd_data), 32'd1);
    check("mrst_nofull", 32'(hit[0]), 32'h0);
    idle_all();
    rd_check("mrst_cnt2", 0, 0, 32'd2);
    check("mrst_hits", 32'(hit), 32'h0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
